// File: rtl/rcv.sv
// rcv - 8N1 serial line receiver (LSB first, idle-high line).
//
// Sits between the board RX pin and the flash programmer's command parser.
// Each received byte is presented on parallel_out with a full/read handshake.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   serial_in     asynchronous RX line, idle high
//   read          one-cycle pulse: consumer has taken parallel_out
//   full          a byte is valid on parallel_out
//   parallel_out  last received byte
//   frame_err     stop bit of the last byte sampled low
//   overrun       (only with RCV_OVERRUN_EN) a byte was overwritten unread
//
// Optional feature: define RCV_OVERRUN_EN to add the sticky overrun flag.
// Without it, a byte arriving while full==1 silently overwrites the old one.
//
// Parameters:
//   BIT_TICKS   clk cycles per bit (count register is 11 bits wide)
//   HALF_TICKS  cycles from the detected start edge to mid start bit

module rcv #(
  parameter int BIT_TICKS  = 1303,
  parameter int HALF_TICKS = BIT_TICKS / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       read,
  output logic       full,
  output logic [7:0] parallel_out,
  output logic       frame_err
`ifdef RCV_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam logic [10:0] BIT_LOAD  = 11'(BIT_TICKS - 1);
  localparam logic [10:0] HALF_LOAD = 11'(HALF_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        sync1;
  logic        rx;
  logic [7:0]  shift;
  logic [10:0] count;
  logic [2:0]  bitcnt;
  logic        tick;

  // count free-runs downwards; every state that waits on it reloads it,
  // so its value only matters between a reload and the next tick.
  assign tick = (count == 11'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sync1        <= 1'b1;
      rx           <= 1'b1;
      shift        <= 8'h00;
      count        <= 11'd0;
      bitcnt       <= 3'd0;
      full         <= 1'b0;
      parallel_out <= 8'h00;
      frame_err    <= 1'b0;
`ifdef RCV_OVERRUN_EN
      overrun      <= 1'b0;
`endif
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
      count <= count - 11'd1;

      // Consumer handshake; a load in the STOP branch below overrides this.
      if (read) begin
        full <= 1'b0;
`ifdef RCV_OVERRUN_EN
        overrun <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            count <= HALF_LOAD;
          end
        end

        START: begin
          if (tick) begin
            if (!rx) begin
              state  <= DATA;
              count  <= BIT_LOAD;
              bitcnt <= 3'd0;
            end else begin
              // Line went back high before mid start bit: glitch, ignore.
              state <= IDLE;
            end
          end
        end

        DATA: begin
          if (tick) begin
            shift  <= {rx, shift[7:1]};
            count  <= BIT_LOAD;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (tick) begin
            parallel_out <= shift;
            full         <= 1'b1;
            frame_err    <= ~rx;
`ifdef RCV_OVERRUN_EN
            if (full && !read) begin
              overrun <= 1'b1;
            end
`endif
            // A low stop bit means the line may be held in break; do not
            // treat the continuing low level as a new start bit.
            state <= rx ? IDLE : BREAK;
          end
        end

        BREAK: begin
          if (rx) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
